rgb_stream_checker: RTL and testbench
=====================================

// Module: rgb_stream_checker
// PURPOSE
// Parametrised in-fabric RGB stream checker; next generation of the rgbAssertion checker.
// - Queues expected pixels from the camera pixel bus (valid/iRed/iGreen/iBlue).
// - Compares them in order against the mm2s AXI-stream read-back (m_axis_mm2s_tvalid/tdata).
// - Keeps saturating match/mismatch counts, sticky error flags and the first-mismatch capture.
// - Adds a drain/timeout state machine.
// - Sits beside the VDMA read path in d5m_camera test builds.
// PARAMETERS
// DATA_WIDTH   8   bits per colour channel
// AXIS_WIDTH   32  tdata width; must be >= 3*DATA_WIDTH
// FIFO_DEPTH   16  expected-pixel queue depth; power of 2, >= 2
// CNT_WIDTH    32  width of match/mismatch counters
// TIMEOUT      1024  DRAIN cycles without tvalid before timeout
// TOL          1   per-channel tolerance; used only with RGB_TOLERANCE_EN
// PORTS
// pixclk               in   1              single clock, rising edge
// reset                in   1              synchronous, active-low
// enable               in   1              1 = accept pixels; 0 = finish and drain
// clear                in   1              synchronous clear of counters, flags and queue
// valid                in   1              expected pixel strobe
// iRed/iGreen/iBlue    in   DATA_WIDTH     expected pixel channels
// m_axis_mm2s_tvalid   in   1              read-back beat strobe (checker is always ready)
// m_axis_mm2s_tdata    in   AXIS_WIDTH     read-back pixel {R,G,B} in low 3*DATA_WIDTH bits
// match_count          out  CNT_WIDTH      beats that compared equal
// mismatch_count       out  CNT_WIDTH      beats that compared unequal
// error                out  1              sticky: any mismatch, overflow, underflow or timeout
// overflow/underflow   out  1              sticky queue faults
// timeout              out  1              sticky drain timeout
// first_err_exp        out  3*DATA_WIDTH   expected pixel of first mismatch
// first_err_got        out  3*DATA_WIDTH   received pixel of first mismatch
// fifo_level           out  $clog2(FIFO_DEPTH)+1  queue occupancy
// state                out  2              IDLE=0, RUN=1, DRAIN=2
// BEHAVIOUR
// - Reset (reset==0) or clear==1: all outputs 0, queue empty, state IDLE. clear wins over same-cycle push/pop.
// - State machine:
//   - IDLE->RUN when enable=1.
//   - RUN->DRAIN when enable=0. DRAIN->RUN if enable returns.
//   - DRAIN->IDLE when fifo_level==0.
//   - DRAIN->IDLE on TIMEOUT consecutive cycles without tvalid: timeout=1, queue flushed.
// - Push: valid=1 in RUN. Ignored in IDLE/DRAIN.
// - Pop: tvalid=1 in RUN or DRAIN. tvalid in IDLE is ignored.
// - Packing: expected = {iRed,iGreen,iBlue}. Received = tdata[3*DATA_WIDTH-1:0]. Upper tdata bits ignored.
// - Push and pop in the same cycle are both legal at any level, including full (level unchanged) and empty.
//   - Empty case: the pixel pushed that cycle is not visible to that pop; the pop is an underflow.
// - Push when full with no pop: pixel dropped, overflow=1.
// - Pop when empty: underflow=1, no compare, counters unchanged.
// - Compare is registered; counters, error and first_err_* update 1 cycle after the pop beat.
// - first_err_* load only on the first mismatch after reset/clear and then hold.
// - Counters saturate at all-ones; no wrap.
// - fifo_level reflects pushes/pops of the previous cycle.
// CONFIGURATION
// RGB_TOLERANCE_EN defined:
// - A beat matches when every channel satisfies |exp-got| <= TOL (unsigned difference, DATA_WIDTH+1 bits).
// RGB_TOLERANCE_EN undefined:
// - Exact equality of all 3*DATA_WIDTH bits; TOL unused.
// TESTING
// 1. Defaults, enable=1. Push 8 pixels (R=i,G=2i,B=3i); return identical tdata 4 cycles later
//    -> match_count=8, mismatch_count=0, error=0, fifo_level=0.
// 2. Push 0x102030, return 0x102031, exact build
//    -> mismatch_count=1, error=1, first_err_exp=0x102030, first_err_got=0x102031.
//    Same stimulus with RGB_TOLERANCE_EN and TOL=1 -> match_count=1, error=0.
// 3. Push 17 pixels with no tvalid
//    -> overflow=1, fifo_level=16. Then 16 beats of the first 16 pixels -> match_count=16.
// 4. tvalid with empty queue -> underflow=1, both counts 0.
//    At full, valid and tvalid in the same cycle -> fifo_level stays 16, no overflow.
// 5. Push 3 pixels, drop enable, no tvalid for TIMEOUT cycles
//    -> state RUN->DRAIN->IDLE, timeout=1, fifo_level=0.
//    Pulse clear -> all counters and flags 0.
// 6. Assert reset mid-stream with 5 pixels queued
//    -> next cycle all outputs 0, state IDLE. Beats during reset are ignored.

Source files
------------

// File: rtl/rgb_stream_checker.sv
// In-fabric RGB stream checker: queues camera pixels and compares them in order against mm2s read-back.
// Optional build macro RGB_TOLERANCE_EN relaxes the compare to a per-channel |exp-got| <= TOL.
module rgb_stream_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned TOL        = 1
) (
  input  logic                              pixclk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic                              valid,
  input  logic [DATA_WIDTH-1:0]             iRed,
  input  logic [DATA_WIDTH-1:0]             iGreen,
  input  logic [DATA_WIDTH-1:0]             iBlue,
  input  logic                              m_axis_mm2s_tvalid,
  input  logic [AXIS_WIDTH-1:0]             m_axis_mm2s_tdata,
  output logic [CNT_WIDTH-1:0]              match_count,
  output logic [CNT_WIDTH-1:0]              mismatch_count,
  output logic                              error,
  output logic                              overflow,
  output logic                              underflow,
  output logic                              timeout,
  output logic [3*DATA_WIDTH-1:0]           first_err_exp,
  output logic [3*DATA_WIDTH-1:0]           first_err_got,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [1:0]                        state
);

  localparam int unsigned PIX_W  = 3 * DATA_WIDTH;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [TO_W-1:0]      r_to_cnt;
  logic [PIX_W-1:0]     r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [CNT_WIDTH-1:0] r_match_cnt;
  logic [CNT_WIDTH-1:0] r_mismatch_cnt;
  logic                 r_error;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_timeout;
  logic                 r_err_seen;
  logic [PIX_W-1:0]     r_first_exp;
  logic [PIX_W-1:0]     r_first_got;

  logic [1:0]           w_state_nxt;
  logic                 w_to_fire;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_ovf;
  logic                 w_udf;
  logic                 w_match;
  logic [PIX_W-1:0]     w_exp_in;
  logic [PIX_W-1:0]     w_head;
  logic [PIX_W-1:0]     w_got;

  assign w_exp_in = {iRed, iGreen, iBlue};
  assign w_got    = m_axis_mm2s_tdata[PIX_W-1:0];
  assign w_head   = r_mem[r_rd_ptr];
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));

  generate
    if (AXIS_WIDTH > PIX_W) begin : g_tdata_hi
      logic w_unused_tdata;
      assign w_unused_tdata = ^m_axis_mm2s_tdata[AXIS_WIDTH-1:PIX_W];
    end
  endgenerate

  // Next state and per-cycle queue controls
  always_comb begin
    w_state_nxt = r_state;
    w_to_fire   = 1'b0;
    w_push      = valid && (r_state == S_RUN);
    w_pop       = m_axis_mm2s_tvalid && ((r_state == S_RUN) || (r_state == S_DRAIN));
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enable) begin
          w_state_nxt = S_RUN;
        end else if (w_empty) begin
          w_state_nxt = S_IDLE;
        end else if (!m_axis_mm2s_tvalid && (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
          w_state_nxt = S_IDLE;
          w_to_fire   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop at full frees a slot, so a same-cycle push is accepted
  assign w_rd  = w_pop && !w_empty;
  assign w_wr  = w_push && (!w_full || w_rd);
  assign w_ovf = w_push && w_full && !w_rd;
  assign w_udf = w_pop && w_empty;

`ifdef RGB_TOLERANCE_EN
  localparam int unsigned DIFF_W = DATA_WIDTH + 1;
  logic [DIFF_W-1:0] w_a;
  logic [DIFF_W-1:0] w_b;
  logic [DIFF_W-1:0] w_diff;

  always_comb begin
    w_match = 1'b1;
    w_a     = '0;
    w_b     = '0;
    w_diff  = '0;
    for (int c = 0; c < 3; c++) begin
      w_a    = {1'b0, w_head[c*DATA_WIDTH +: DATA_WIDTH]};
      w_b    = {1'b0, w_got[c*DATA_WIDTH +: DATA_WIDTH]};
      w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
      if (w_diff > DIFF_W'(TOL)) w_match = 1'b0;
    end
  end
`else
  logic w_unused_tol;
  assign w_unused_tol = (TOL != 0);
  assign w_match      = (w_head == w_got);
`endif

  // Queue storage; contents beyond the pointers are don't-care so no reset
  always_ff @(posedge pixclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_exp_in;
  end

  always_ff @(posedge pixclk) begin
    if (!reset || clear) begin
      r_state        <= S_IDLE;
      r_to_cnt       <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_error        <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_timeout      <= 1'b0;
      r_err_seen     <= 1'b0;
      r_first_exp    <= '0;
      r_first_got    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_DRAIN) && !m_axis_mm2s_tvalid && !w_to_fire)
        r_to_cnt <= r_to_cnt + TO_W'(1);
      else
        r_to_cnt <= '0;

      if (w_to_fire) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_level   <= '0;
        r_timeout <= 1'b1;
        r_error   <= 1'b1;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_level <= r_level + LVL_W'(w_wr) - LVL_W'(w_rd);
      end

      if (w_ovf) begin
        r_overflow <= 1'b1;
        r_error    <= 1'b1;
      end
      if (w_udf) begin
        r_underflow <= 1'b1;
        r_error     <= 1'b1;
      end

      // Compare result lands in the counters on the edge that takes the beat
      if (w_rd) begin
        if (w_match) begin
          if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_WIDTH'(1);
        end else begin
          if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNT_WIDTH'(1);
          r_error <= 1'b1;
          if (!r_err_seen) begin
            r_err_seen  <= 1'b1;
            r_first_exp <= w_head;
            r_first_got <= w_got;
          end
        end
      end
    end
  end

  assign match_count    = r_match_cnt;
  assign mismatch_count = r_mismatch_cnt;
  assign error          = r_error;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;
  assign timeout        = r_timeout;
  assign first_err_exp  = r_first_exp;
  assign first_err_got  = r_first_got;
  assign fifo_level     = r_level;
  assign state          = r_state;

endmodule

// File: tb/tb_rgb_stream_checker.sv
// Directed bench for rgb_stream_checker at default parameters; expectations follow RGB_TOLERANCE_EN if defined.
module tb_rgb_stream_checker;

  logic        pixclk = 1'b0;
  logic        reset  = 1'b0;
  logic        enable = 1'b0;
  logic        clear  = 1'b0;
  logic        valid  = 1'b0;
  logic [7:0]  iRed   = '0;
  logic [7:0]  iGreen = '0;
  logic [7:0]  iBlue  = '0;
  logic        m_axis_mm2s_tvalid = 1'b0;
  logic [31:0] m_axis_mm2s_tdata  = '0;
  logic [31:0] match_count;
  logic [31:0] mismatch_count;
  logic        error;
  logic        overflow;
  logic        underflow;
  logic        timeout;
  logic [23:0] first_err_exp;
  logic [23:0] first_err_got;
  logic [4:0]  fifo_level;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fails  = 0;

  rgb_stream_checker dut (
    .pixclk             (pixclk),
    .reset              (reset),
    .enable             (enable),
    .clear              (clear),
    .valid              (valid),
    .iRed               (iRed),
    .iGreen             (iGreen),
    .iBlue              (iBlue),
    .m_axis_mm2s_tvalid (m_axis_mm2s_tvalid),
    .m_axis_mm2s_tdata  (m_axis_mm2s_tdata),
    .match_count        (match_count),
    .mismatch_count     (mismatch_count),
    .error              (error),
    .overflow           (overflow),
    .underflow          (underflow),
    .timeout            (timeout),
    .first_err_exp      (first_err_exp),
    .first_err_got      (first_err_got),
    .fifo_level         (fifo_level),
    .state              (state)
  );

  always #5 pixclk = ~pixclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  function automatic logic [23:0] pix(input int i);
    return {8'(i), 8'(2 * i), 8'(3 * i)};
  endfunction

  task automatic drive(input logic v, input logic [23:0] p, input logic tv, input logic [31:0] d);
    valid = v;
    {iRed, iGreen, iBlue} = p;
    m_axis_mm2s_tvalid = tv;
    m_axis_mm2s_tdata = d;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 24'h0, 1'b0, 32'h0);
  endtask

  // Clear then spend one cycle so that enable=1 reaches RUN
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".match"}, 64'(match_count), 64'd0);
    check({tag, ".mismatch"}, 64'(mismatch_count), 64'd0);
    check({tag, ".flags"}, 64'({error, overflow, underflow, timeout}), 64'd0);
    check({tag, ".first_exp"}, 64'(first_err_exp), 64'd0);
    check({tag, ".first_got"}, 64'(first_err_got), 64'd0);
    check({tag, ".level"}, 64'(fifo_level), 64'd0);
    check({tag, ".state"}, 64'(state), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check("reset.idle_hold", 64'(state), 64'd0);

    // 1: eight pixels returned four cycles later, overlapping push/pop
    enable = 1'b1;
    tick();
    check("t1.run", 64'(state), 64'd1);
    for (int c = 0; c < 12; c++) begin
      drive(c < 8, pix(c + 1), c >= 4, {8'h00, pix(c - 3)});
      tick();
      if (c == 3) check("t1.level4", 64'(fifo_level), 64'd4);
    end
    idle_inputs();
    tick();
    check("t1.match", 64'(match_count), 64'd8);
    check("t1.mismatch", 64'(mismatch_count), 64'd0);
    check("t1.error", 64'(error), 64'd0);
    check("t1.level", 64'(fifo_level), 64'd0);

    // 2: off-by-one blue channel, upper tdata bits set and ignored
    do_clear();
    drive(1'b1, 24'h102030, 1'b0, 32'h0);
    tick();
    drive(1'b0, 24'h0, 1'b1, 32'hFF102031);
    tick();
    idle_inputs();
    tick();
`ifdef RGB_TOLERANCE_EN
    check("t2.match", 64'(match_count), 64'd1);
    check("t2.mismatch", 64'(mismatch_count), 64'd0);
    check("t2.error", 64'(error), 64'd0);
`else
    check("t2.match", 64'(match_count), 64'd0);
    check("t2.mismatch", 64'(mismatch_count), 64'd1);
    check("t2.error", 64'(error), 64'd1);
    check("t2.first_exp", 64'(first_err_exp), 64'h102030);
    check("t2.first_got", 64'(first_err_got), 64'h102031);
`endif
    drive(1'b1, 24'h111111, 1'b0, 32'h0);
    tick();
    drive(1'b0, 24'h0, 1'b1, 32'h00222222);
    tick();
    idle_inputs();
    tick();
`ifdef RGB_TOLERANCE_EN
    check("t2b.mismatch", 64'(mismatch_count), 64'd1);
    check("t2b.first_exp", 64'(first_err_exp), 64'h111111);
    check("t2b.first_got", 64'(first_err_got), 64'h222222);
`else
    check("t2b.mismatch", 64'(mismatch_count), 64'd2);
    check("t2b.first_exp_hold", 64'(first_err_exp), 64'h102030);
    check("t2b.first_got_hold", 64'(first_err_got), 64'h102031);
`endif

    // 3: overflow on the seventeenth push, then drain the sixteen kept
    do_clear();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, pix(i), 1'b0, 32'h0);
      tick();
      if (i == 15) check("t3.no_ovf_at_16", 64'(overflow), 64'd0);
    end
    idle_inputs();
    tick();
    check("t3.overflow", 64'(overflow), 64'd1);
    check("t3.error", 64'(error), 64'd1);
    check("t3.level_full", 64'(fifo_level), 64'd16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 24'h0, 1'b1, {8'h00, pix(i)});
      tick();
    end
    idle_inputs();
    tick();
    check("t3.match", 64'(match_count), 64'd16);
    check("t3.mismatch", 64'(mismatch_count), 64'd0);
    check("t3.level_empty", 64'(fifo_level), 64'd0);
    check("t3.underflow", 64'(underflow), 64'd0);

    // 4a: beat with empty queue
    do_clear();
    drive(1'b0, 24'h0, 1'b1, 32'h00ABCDEF);
    tick();
    idle_inputs();
    tick();
    check("t4.underflow", 64'(underflow), 64'd1);
    check("t4.match", 64'(match_count), 64'd0);
    check("t4.mismatch", 64'(mismatch_count), 64'd0);

    // 4b: push and pop together at full
    do_clear();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, pix(i), 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, pix(16), 1'b1, {8'h00, pix(0)});
    tick();
    idle_inputs();
    tick();
    check("t4.level_full", 64'(fifo_level), 64'd16);
    check("t4.no_overflow", 64'(overflow), 64'd0);
    check("t4.match1", 64'(match_count), 64'd1);

    // 4c: push and pop together when empty is an underflow, pixel kept
    do_clear();
    drive(1'b1, pix(5), 1'b1, {8'h00, pix(5)});
    tick();
    idle_inputs();
    tick();
    check("t4c.underflow", 64'(underflow), 64'd1);
    check("t4c.level", 64'(fifo_level), 64'd1);
    check("t4c.match", 64'(match_count), 64'd0);

    // 5: drain timeout with three pixels stranded
    do_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pix(i), 1'b0, 32'h0);
      tick();
    end
    idle_inputs();
    check("t5.run", 64'(state), 64'd1);
    enable = 1'b0;
    tick();
    check("t5.drain", 64'(state), 64'd2);
    for (int i = 0; i < 1023; i++) tick();
    check("t5.still_drain", 64'(state), 64'd2);
    check("t5.no_timeout_yet", 64'(timeout), 64'd0);
    tick();
    check("t5.idle", 64'(state), 64'd0);
    check("t5.timeout", 64'(timeout), 64'd1);
    check("t5.error", 64'(error), 64'd1);
    check("t5.level", 64'(fifo_level), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check_all_zero("t5.clear");

    // 6: reset mid-stream, beats during reset ignored
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, pix(i), 1'b0, 32'h0);
      tick();
    end
    check("t6.level5", 64'(fifo_level), 64'd5);
    drive(1'b0, 24'h0, 1'b1, {8'h00, pix(0)});
    reset = 1'b0;
    tick();
    check_all_zero("t6.reset");
    tick();
    check_all_zero("t6.reset_hold");
    idle_inputs();
    reset = 1'b1;
    tick();
    check("t6.run_again", 64'(state), 64'd1);
    check("t6.level_after", 64'(fifo_level), 64'd0);
    check("t6.match_after", 64'(match_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
